// File: rtl/recip_mul.sv
// Signed Q12.12 multiply of an operand by a reciprocal via a 24-step serial shift-add, with saturation.
// Result is valid 25 clocks after accept; the result is held in DONE until i_ready, and o_ready is low while busy.
module recip_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [23:0] i_a,
    input  logic [23:0] i_b,
    input  logic        i_b_sat,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [23:0] o_data,
    output logic        o_sat
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [47:0] r_acc;
    logic [47:0] r_a_sh;
    logic [23:0] r_b_sh;
    logic        r_sign;
    logic        r_b_sat;
    logic [23:0] r_data;
    logic        r_sat;

    logic        w_accept;
    logic        w_last;
    logic [23:0] w_a_mag;
    logic [23:0] w_b_mag;
    logic [35:0] w_m;
    logic [23:0] w_res;
    logic        w_res_sat;

    assign w_accept = i_valid && (r_state == S_IDLE);
    // Count 24 marks the extra BUSY cycle that scales, clamps and registers the result.
    assign w_last   = (r_cnt == 5'd24);
    // Negating 0x800000 gives 0x800000, which is the correct unsigned magnitude.
    assign w_a_mag  = i_a[23] ? (~i_a + 24'd1) : i_a;
    assign w_b_mag  = i_b[23] ? (~i_b + 24'd1) : i_b;
    assign w_m      = r_acc[47:12];

    assign o_ready  = (r_state == S_IDLE);
    assign o_valid  = (r_state == S_DONE);
    assign o_data   = r_data;
    assign o_sat    = r_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_BUSY;
            S_BUSY:  if (w_last)   w_next = S_DONE;
            S_DONE:  if (i_ready)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_res     = 24'h000000;
        w_res_sat = 1'b0;
        if (w_m == 36'd0) begin
            w_res     = 24'h000000;
            w_res_sat = 1'b0;
        end else if (r_b_sat) begin
            w_res     = r_sign ? 24'h800000 : 24'h7FFFFF;
            w_res_sat = 1'b1;
        end else if (!r_sign && (w_m > 36'h7FFFFF)) begin
            w_res     = 24'h7FFFFF;
            w_res_sat = 1'b1;
        end else if (r_sign && (w_m > 36'h800000)) begin
            w_res     = 24'h800000;
            w_res_sat = 1'b1;
        end else begin
            w_res     = r_sign ? (~w_m[23:0] + 24'd1) : w_m[23:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 5'd0;
            r_acc   <= 48'd0;
            r_a_sh  <= 48'd0;
            r_b_sh  <= 24'd0;
            r_sign  <= 1'b0;
            r_b_sat <= 1'b0;
            r_data  <= 24'h000000;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_sh  <= {24'd0, w_a_mag};
                        r_b_sh  <= w_b_mag;
                        r_sign  <= i_a[23] ^ i_b[23];
                        r_b_sat <= i_b_sat;
                        r_acc   <= 48'd0;
                        r_cnt   <= 5'd0;
                    end
                end
                S_BUSY: begin
                    if (!w_last) begin
                        if (r_b_sh[0]) r_acc <= r_acc + r_a_sh;
                        r_a_sh <= r_a_sh << 1;
                        r_b_sh <= r_b_sh >> 1;
                        r_cnt  <= r_cnt + 5'd1;
                    end else begin
                        r_data <= w_res;
                        r_sat  <= w_res_sat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_recip_mul.sv
// Directed-vector bench for recip_mul: result table, latency, backpressure and reset abort.
module tb_recip_mul;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [23:0] i_a;
    logic [23:0] i_b;
    logic        i_b_sat;
    logic        o_valid;
    logic        i_ready;
    logic [23:0] o_data;
    logic        o_sat;

    int n_tests;
    int n_fail;

    recip_mul dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_b_sat (i_b_sat),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_sat   (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [23:0] a;
        logic [23:0] b;
        logic        bs;
        logic [23:0] exp_d;
        logic        exp_s;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for o_ready, presents one operand pair, returns the result and accept-to-valid latency.
    task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic bs,
                          output logic [23:0] d, output logic s, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!o_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: o_ready stuck at 0, expected 1");
        end
        i_a = a; i_b = b; i_b_sat = bs; i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d = o_data;
        s = o_sat;
    endtask

    initial begin
        logic [23:0] d;
        logic        s;
        int          lat;
        logic [23:0] held;
        int          seen;

        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{"one_x_one",      24'h001000, 24'h001000, 1'b0, 24'h001000, 1'b0};
        vecs[1]  = '{"neg_frac",       24'h002800, 24'hFFFC00, 1'b0, 24'hFFF600, 1'b0};
        vecs[2]  = '{"trunc_to_zero",  24'h000001, 24'h000001, 1'b0, 24'h000000, 1'b0};
        vecs[3]  = '{"pos_clamp",      24'h100000, 24'h100000, 1'b0, 24'h7FFFFF, 1'b1};
        vecs[4]  = '{"neg_clamp",      24'h100000, 24'hF00000, 1'b0, 24'h800000, 1'b1};
        vecs[5]  = '{"bsat_neg",       24'hFFF000, 24'h7FFFFF, 1'b1, 24'h800000, 1'b1};
        vecs[6]  = '{"bsat_zero_a",    24'h000000, 24'h7FFFFF, 1'b1, 24'h000000, 1'b0};
        vecs[7]  = '{"neg_min_exact",  24'h800000, 24'h001000, 1'b0, 24'h800000, 1'b0};
        vecs[8]  = '{"pos_min_clamp",  24'h800000, 24'hFFF000, 1'b0, 24'h7FFFFF, 1'b1};
        vecs[9]  = '{"neg_zero",       24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b0};
        vecs[10] = '{"pos_max_exact",  24'h7FFFFF, 24'h001000, 1'b0, 24'h7FFFFF, 1'b0};
        vecs[11] = '{"bsat_pos",       24'h000800, 24'h000010, 1'b1, 24'h7FFFFF, 1'b1};

        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_a = 24'h0; i_b = 24'h0; i_b_sat = 1'b0;
        #12;
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_o_data",  {8'd0, o_data},   32'h0);
        chk("rst_o_sat",   {31'd0, o_sat},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bs, d, s, lat);
            chk({vecs[i].name, "_data"}, {8'd0, d}, {8'd0, vecs[i].exp_d});
            chk({vecs[i].name, "_sat"},  {31'd0, s}, {31'd0, vecs[i].exp_s});
            chk({vecs[i].name, "_lat"},  lat, 32'd25);
        end

        // Result is retained in IDLE after the handshake.
        @(posedge clk); #1;
        chk("retain_ready", {31'd0, o_ready}, 32'd1);
        chk("retain_data",  {8'd0, o_data},   32'h7FFFFF);
        chk("retain_sat",   {31'd0, o_sat},   32'd1);

        // Backpressure: DONE holds while new operands are offered.
        i_ready = 1'b0;
        run_op(24'h002800, 24'hFFFC00, 1'b0, d, s, lat);
        chk("bp_lat", lat, 32'd25);
        held = o_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_valid = 1'b1; i_a = 24'h001000 + 24'(k); i_b = 24'h003000; i_b_sat = 1'b0;
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, o_valid}, 32'd1);
            chk("bp_ready", {31'd0, o_ready}, 32'd0);
            chk("bp_data",  {8'd0, o_data},   32'hFFF600);
        end
        @(negedge clk);
        i_ready = 1'b1; i_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, o_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, o_ready}, 32'd1);
        chk("bp_release_data",  {8'd0, o_data},   {8'd0, held});
        // Operands offered during DONE must not have started an operation.
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_accept", {31'd0, o_ready}, 32'd1);

        // Reset abort at BUSY iteration 10.
        @(negedge clk);
        i_a = 24'h003000; i_b = 24'h002000; i_b_sat = 1'b0; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, o_valid}, 32'd0);
        chk("abort_ready", {31'd0, o_ready}, 32'd1);
        chk("abort_data",  {8'd0, o_data},   32'h0);
        chk("abort_sat",   {31'd0, o_sat},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        chk("abort_no_result", seen, 32'd0);

        // First accept right after reset release, then a normal operation.
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(24'h003000, 24'h002000, 1'b0, d, s, lat);
        chk("post_rst_data", {8'd0, d}, 32'h006000);
        chk("post_rst_sat",  {31'd0, s}, 32'd0);
        chk("post_rst_lat",  lat, 32'd25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/recip_mul.md
RECIP_MUL -- requirements
Module: recip_mul

Interface
REQ-001 SHALL have no parameters; format fixed at signed Q12.12, 24 bits (1.0 = 0x001000).
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: i_valid  in  1  upstream operand pair valid.
REQ-005 SHALL have ports: o_ready  out  1  block can accept operands.
REQ-006 SHALL have ports: i_a  in  24  multiplicand, signed Q12.12.
REQ-007 SHALL have ports: i_b  in  24  reciprocal value, signed Q12.12.
REQ-008 SHALL have ports: i_b_sat  in  1  reciprocal generator saturated flag.
REQ-009 SHALL have ports: o_valid  out  1  result valid.
REQ-010 SHALL have ports: i_ready  in  1  downstream accepts result.
REQ-011 SHALL have ports: o_data  out  24  product, signed Q12.12.
REQ-012 SHALL have ports: o_sat  out  1  result clamped.

Function
REQ-013 SHALL implement FSM IDLE, BUSY, DONE; o_ready = 1 only in IDLE; o_valid = 1 only in DONE.
REQ-014 IDLE: on i_valid & o_ready, SHALL capture i_a, i_b, i_b_sat, sign = i_a[23]^i_b[23], unsigned magnitudes |i_a|, |i_b| (24-bit unsigned, |0x800000| = 0x800000); go to BUSY.
REQ-015 BUSY: SHALL run exactly 24 shift-add iterations (5-bit counter), one bit of |i_b| per clock, into a 48-bit unsigned accumulator; then go to DONE.
REQ-016 Latency: o_valid SHALL rise exactly 25 clocks after the accepting edge, independent of operand values or i_b_sat.
REQ-017 Scaling: magnitude M = accumulator >> 12 (truncation toward zero).
REQ-018 Clamp: sign=0 and M > 0x7FFFFF -> o_data = 0x7FFFFF, o_sat = 1; sign=1 and M > 0x800000 -> o_data = 0x800000, o_sat = 1.
REQ-019 Otherwise o_data = sign ? -M : M (two's complement, 24 bits), o_sat = 0; M = 0x800000 with sign=1 gives 0x800000, o_sat = 0; M = 0 gives 0x000000 regardless of sign.
REQ-020 Captured i_b_sat = 1 SHALL override: o_data = sign ? 0x800000 : 0x7FFFFF, o_sat = 1, except M = 0 (i_a = 0) gives 0x000000, o_sat = 0.
REQ-021 o_data/o_sat SHALL be registered, updated only on BUSY->DONE transition, and held stable throughout DONE.
REQ-022 DONE: on i_ready = 1 SHALL return to IDLE; while i_ready = 0 SHALL stay in DONE (backpressure, no timeout).
REQ-023 i_valid, i_a, i_b, i_b_sat SHALL be ignored outside IDLE; no operand queuing.
REQ-024 Throughput: at most one operation per 27 clocks (accept, 24 BUSY, DONE handshake, IDLE); no IDLE skip.
REQ-025 o_data/o_sat SHALL retain last result after DONE->IDLE until next BUSY->DONE.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, o_ready = 1 (while rst_n high thereafter), o_valid = 0, o_data = 0x000000, o_sat = 0, counter and accumulator = 0.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation; no result SHALL be presented after release.
REQ-028 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 i_a=0x001000, i_b=0x001000, i_b_sat=0 -> o_data=0x001000, o_sat=0, o_valid rises 25 clocks after accept.
REQ-030 i_a=0x002800 (2.5), i_b=0xFFFC00 (-0.25) -> o_data=0xFFF600 (-0.625), o_sat=0; i_a=0x000001, i_b=0x000001 -> 0x000000.
REQ-031 i_a=0x100000, i_b=0x100000 -> 0x7FFFFF, o_sat=1; i_a=0x100000, i_b=0xF00000 -> 0x800000, o_sat=1.
REQ-032 i_a=0xFFF000 (-1.0), i_b=0x7FFFFF, i_b_sat=1 -> 0x800000, o_sat=1; i_a=0, i_b_sat=1 -> 0x000000, o_sat=0.
REQ-033 Backpressure: i_ready=0 for 5 clocks in DONE with i_valid=1 and changing operands -> o_data stable, o_ready=0, no new accept; i_ready=1 -> IDLE next clock.
REQ-034 rst_n pulsed low at BUSY iteration 10 -> all outputs at reset values asynchronously, o_valid never asserts for aborted operation; next operation correct.
